// File: rtl/stage3_word_arbiter_if.sv
// stage3_word_arbiter_if: lane request/word bus and downstream valid/ready port of the Stage3 word arbiter
interface stage3_word_arbiter_if #(
    parameter int WIDTH   = 128,
    parameter int NUM_REQ = 4,
    parameter int CNTW    = 16,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       i_req;
    logic [NUM_REQ*WIDTH-1:0] i_word;
    logic [NUM_REQ-1:0]       o_grant;
    logic                     o_valid;
    logic [WIDTH-1:0]         o_word;
    logic [IDW-1:0]           o_src;
    logic                     i_ready;
    logic [CNTW-1:0]          o_count;
    modport master (output i_req, i_word, i_ready, input o_grant, o_valid, o_word, o_src, o_count);
    modport slave (input i_req, i_word, i_ready, output o_grant, o_valid, o_word, o_src, o_count);
endinterface

// File: rtl/stage3_word_arbiter.sv
// stage3_word_arbiter: round-robin loader of the shared Stage3 output word register with valid/ready drain
module stage3_word_arbiter #(
    parameter int WIDTH   = 128,
    parameter int NUM_REQ = 4,
    parameter int CNTW    = 16
) (
    input logic i_clk,
    input logic i_reset,
    stage3_word_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           state, state_nx;
    logic [IDW-1:0]   ptr, gidx;
    logic [IDW-1:0]   cand [NUM_REQ];
    logic             found, free, gnt;
    logic [WIDTH-1:0] word_q;
    logic [IDW-1:0]   src_q;
    logic [CNTW-1:0]  count_q;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
        assign cand[g] = IDW'((int'(ptr) + g) % NUM_REQ);
    end
    assign free = (state == EMPTY) || bus.i_ready;
    // Scan from the farthest offset down so the requester nearest ptr wins
    always_comb begin
        found = 1'b0;
        gidx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.i_req[cand[i]]) begin
                found = 1'b1;
                gidx = cand[i];
            end
        end
    end
    // Grant when the register is free; a grant always lands the register in FULL
    always_comb begin
        gnt = i_reset && free && found;
        state_nx = gnt ? FULL : (state == FULL && bus.i_ready) ? EMPTY : state;
        bus.o_grant = gnt ? NUM_REQ'(1) << gidx : '0;
    end
    // State register
    always_ff @(posedge i_clk) begin
        state <= i_reset ? state_nx : EMPTY;
    end
    // Holding register, source id, round-robin pointer and transfer counter
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            word_q <= '0;
            src_q <= '0;
            ptr <= '0;
            count_q <= '0;
        end else begin
            if (gnt) begin
                word_q <= bus.i_word[gidx*WIDTH +: WIDTH];
                src_q <= gidx;
                ptr <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            end
            if (bus.o_valid && bus.i_ready) count_q <= count_q + CNTW'(1);
        end
    end
    assign bus.o_valid = (state == FULL);
    assign bus.o_word = word_q;
    assign bus.o_src = src_q;
    assign bus.o_count = count_q;
endmodule

// File: tb/tb_stage3_word_arbiter.sv
// tb_stage3_word_arbiter: directed and random checks of the arbiter against a cycle-level reference model
module tb_stage3_word_arbiter;
    localparam int W = 128;
    localparam int N = 4;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst;
    logic [W-1:0] lw [N];
    logic mvalid;
    logic [W-1:0] mword;
    int msrc, mptr, mcount;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    stage3_word_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .CNTW(CW)) bus ();
    stage3_word_arbiter #(.WIDTH(W), .NUM_REQ(N), .CNTW(CW)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
    assign bus.i_word = {lw[3], lw[2], lw[1], lw[0]};

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic cycle();
        int g;
        logic [N-1:0] eg;
        @(negedge clk);
        g = pick(bus.i_req, mptr);
        eg = (rst && (!mvalid || bus.i_ready) && g >= 0) ? N'(1 << g) : '0;
        chk("grant", bus.o_grant, eg);
        chk("valid", bus.o_valid, mvalid);
        chk("word", bus.o_word, mword);
        chk("src", bus.o_src, msrc);
        chk("count", bus.o_count, mcount);
        if (!rst) begin
            mvalid = 0; mword = '0; msrc = 0; mptr = 0; mcount = 0;
        end else begin
            if (mvalid && bus.i_ready) mcount = (mcount + 1) % (1 << CW);
            if (eg != 0) begin
                mword = lw[g]; msrc = g; mptr = (g + 1) % N; mvalid = 1;
            end else if (mvalid && bus.i_ready) mvalid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0;
        bus.i_req = '1;
        bus.i_ready = 1;
        for (int i = 0; i < N; i++) lw[i] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        mvalid = 0; mword = '0; msrc = 0; mptr = 0; mcount = 0;
        cycle();
        cycle();
        chk("rst_grant", bus.o_grant, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_word", bus.o_word, 0);
        // single lane
        rst = 1;
        bus.i_req = 4'b0100;
        lw[2] = {16{8'hA5}};
        #1;
        chk("single_grant", bus.o_grant, 4'b0100);
        cycle();
        chk("single_word", bus.o_word, {16{8'hA5}});
        chk("single_src", bus.o_src, 2);
        bus.i_req = '0;
        cycle();
        chk("single_valid_drop", bus.o_valid, 0);
        chk("single_count", bus.o_count, 1);
        // round robin from a fresh pointer
        rst = 0;
        cycle();
        rst = 1;
        for (int k = 0; k < N; k++) lw[k] = W'(k + 1);
        bus.i_req = '1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_word", bus.o_word, (i % 4) + 1);
        end
        bus.i_req = '0;
        cycle();
        chk("rr_count", bus.o_count, 6);
        // backpressure
        bus.i_req = 4'b0001;
        lw[0] = 128'hDEADBEEF;
        bus.i_ready = 0;
        cycle();
        bus.i_req = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_hold_word", bus.o_word, 128'hDEADBEEF);
            chk("bp_no_grant", bus.o_grant, 0);
        end
        bus.i_ready = 1;
        #1;
        chk("bp_release_grant", bus.o_grant, 4'b0010);
        cycle();
        chk("bp_no_bubble", bus.o_valid, 1);
        chk("bp_src", bus.o_src, 1);
        // reset mid-operation
        bus.i_req = 4'b1000;
        cycle();
        bus.i_req = '0;
        bus.i_ready = 0;
        cycle();
        chk("mid_src3", bus.o_src, 3);
        rst = 0;
        bus.i_req = 4'b1010;
        cycle();
        chk("mid_valid", bus.o_valid, 0);
        chk("mid_count", bus.o_count, 0);
        rst = 1;
        bus.i_ready = 1;
        #1;
        chk("mid_grant_lane1", bus.o_grant, 4'b0010);
        cycle();
        chk("mid_src1", bus.o_src, 1);
        // counter wrap
        rst = 0;
        cycle();
        rst = 1;
        bus.i_req = 4'b0001;
        bus.i_ready = 1;
        for (int i = 0; i < 18; i++) begin
            cycle();
            if (i >= 15) chk("wrap_count", bus.o_count, i % 16);
        end
        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            bus.i_req = N'($urandom);
            bus.i_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) lw[k] = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
